// File: rtl/ibex_rf_wr_arbiter.sv
// ibex_rf_wr_arbiter
//
// This block shares the single register-file write port between two writers:
// the EX stage (ALU/MUL results) and the LSU (load data).
//
// The LSU always wins, because a load response cannot be held back. When an EX
// write collides with an LSU write, the EX write is parked in a one-entry
// holding buffer. The buffer is written out on the next cycle that has no LSU
// write.
//
// Optional build macro RF_INIT_SWEEP_EN:
//   - Defined: after reset the block writes zero to every register from 1 up
//     to the last register. The latch-based register file has no reset of its
//     own. busy_o is high for the whole sweep.
//   - Undefined: reset goes straight to IDLE and busy_o is tied low.
//
// Handshake (EX and LSU ports):
//   - A requester drives req_i together with addr_i and data_i.
//   - The request is consumed in a cycle exactly when the matching gnt_o is
//     high in that cycle.
//   - gnt_o is combinational from req_i and the current state.
//   - A requester that is not granted keeps req_i, addr_i and data_i stable
//     until it is granted.
//   - The LSU is never refused outside the init sweep.
//
// Writes to x0 are granted but are never written to the register file.

module ibex_rf_wr_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,

  input  logic                 ex_req_i,
  input  logic [4:0]           ex_addr_i,
  input  logic [DataWidth-1:0] ex_data_i,
  output logic                 ex_gnt_o,

  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_data_i,
  output logic                 lsu_gnt_o,

  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,

  output logic                 pend_valid_o,
  output logic [4:0]           pend_addr_o,
  output logic                 busy_o,

  // Current FSM state: 0 = INIT, 1 = IDLE, 2 = HELD.
  output logic [1:0]           dbg_state_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    HELD = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Registered write port.
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

  // One-entry holding buffer for a displaced EX write.
  // It is "full" exactly when the FSM is in HELD.
  logic [AddrWidth-1:0] pend_addr_q;
  logic [DataWidth-1:0] pend_data_q;
  logic                 buf_load;

  logic                 busy;
  logic [AddrWidth-1:0] ex_addr, lsu_addr;
  logic                 ex_wr, lsu_wr;

  // Zero-extend a truncated register index back to the 5-bit port width.
  function automatic logic [4:0] zext(input logic [AddrWidth-1:0] a);
    logic [4:0] r;
    r = '0;
    r[AddrWidth-1:0] = a;
    return r;
  endfunction

  // Only the low AddrWidth address bits are meaningful.
  // In an RV32E build the top bit of each address port is ignored.
  assign ex_addr  = ex_addr_i[AddrWidth-1:0];
  assign lsu_addr = lsu_addr_i[AddrWidth-1:0];

  logic unused_addr_msb;
  assign unused_addr_msb = ex_addr_i[4] ^ lsu_addr_i[4];

`ifdef RF_INIT_SWEEP_EN
  // Sweep counter.
  // It starts at 1 because x0 is hard-wired to zero and needs no write.
  localparam logic [AddrWidth-1:0] CntLast = {AddrWidth{1'b1}};
  logic [AddrWidth-1:0] cnt_q;

  assign busy = (state_q == INIT);

  // Advance the sweep counter once per cycle while in INIT.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= AddrWidth'(1);
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + AddrWidth'(1);
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Grants.
  // EX is refused only while the buffer is full and the LSU also wants the
  // port, because there is nowhere left to park the EX write.
  assign lsu_gnt_o = lsu_req_i & ~busy;
  assign ex_gnt_o  = ex_req_i & ~busy & (~pend_valid_o | ~lsu_req_i);

  // A granted request that really writes the register file (not x0).
  assign lsu_wr = lsu_gnt_o & (lsu_addr != '0);
  assign ex_wr  = ex_gnt_o & (ex_addr != '0);

  // Next-state logic and selection of the write source.
  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    buf_load   = 1'b0;

    unique case (state_q)
      INIT: begin
`ifdef RF_INIT_SWEEP_EN
        rf_we_d    = 1'b1;
        rf_waddr_d = zext(cnt_q);
        rf_wdata_d = '0;
        if (cnt_q == CntLast) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      IDLE: begin
        if (lsu_wr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = zext(lsu_addr);
          rf_wdata_d = lsu_data_i;
          // The LSU took the port, so a real EX write has to wait in the
          // buffer.
          if (ex_wr) begin
            buf_load = 1'b1;
            state_d  = HELD;
          end
        end else if (ex_wr) begin
          // The port is free. This includes the case of an LSU write to x0,
          // which uses no port slot.
          rf_we_d    = 1'b1;
          rf_waddr_d = zext(ex_addr);
          rf_wdata_d = ex_data_i;
        end
      end

      HELD: begin
        if (lsu_wr) begin
          // The load wins again and the buffered EX write keeps waiting.
          // EX is not granted in this cycle.
          rf_we_d    = 1'b1;
          rf_waddr_d = zext(lsu_addr);
          rf_wdata_d = lsu_data_i;
        end else begin
          // No real LSU write (none at all, or one to x0): drain the buffer.
          rf_we_d    = 1'b1;
          rf_waddr_d = zext(pend_addr_q);
          rf_wdata_d = pend_data_q;
          // A granted EX write in this cycle refills the buffer that was
          // just emptied, so the state stays HELD.
          if (ex_wr) begin
            buf_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register and the registered write port.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
`ifdef RF_INIT_SWEEP_EN
      state_q <= INIT;
`else
      state_q <= IDLE;
`endif
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Capture a displaced or refilled EX write into the holding buffer.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else if (buf_load) begin
      pend_addr_q <= ex_addr;
      pend_data_q <= ex_data_i;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign pend_valid_o = (state_q == HELD);
  assign pend_addr_o  = zext(pend_addr_q);
  assign busy_o       = busy;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Testbench for ibex_rf_wr_arbiter.
//
// The main instance is RV32I. A second RV32E instance is used only for the
// address truncation check.
//
// Builds with or without RF_INIT_SWEEP_EN.
//
// Expected register-file writes are pushed to exp_q when they are granted.
// A negedge monitor pops one entry for every rf_we_o pulse and compares it.

`timescale 1ns/1ps

module tb_ibex_rf_wr_arbiter;

  localparam int DW = 32;

`ifdef RF_INIT_SWEEP_EN
  localparam logic       EXP_BUSY_RST  = 1'b1;
  localparam logic [1:0] EXP_STATE_RST = 2'd0;
`else
  localparam logic       EXP_BUSY_RST  = 1'b0;
  localparam logic [1:0] EXP_STATE_RST = 2'd1;
`endif

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk_int = 1'b0;
  logic rst_ni  = 1'b1;

  always #5 clk_int = ~clk_int;

  // ---------------------------------------------------------------------------
  // Stimulus signals, shared by both instances
  // ---------------------------------------------------------------------------
  logic          ex_req, lsu_req, ex_req_e;
  logic [4:0]    ex_addr, lsu_addr;
  logic [DW-1:0] ex_data, lsu_data;

  // ---------------------------------------------------------------------------
  // Main (RV32I) instance outputs
  // ---------------------------------------------------------------------------
  logic          ex_gnt, lsu_gnt, rf_we, pend_valid, busy;
  logic [4:0]    rf_waddr, pend_addr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    dbg_state;

  // ---------------------------------------------------------------------------
  // RV32E instance outputs
  // ---------------------------------------------------------------------------
  logic          ex_gnt_e, lsu_gnt_e, rf_we_e, pend_valid_e, busy_e;
  logic [4:0]    rf_waddr_e, pend_addr_e;
  logic [DW-1:0] rf_wdata_e;
  logic [1:0]    dbg_state_e;

  // ---------------------------------------------------------------------------
  // Instances
  // ---------------------------------------------------------------------------
  ibex_rf_wr_arbiter #(.RV32E(1'b0), .DataWidth(DW)) u_dut (
    .clk_int      (clk_int),
    .rst_ni       (rst_ni),
    .ex_req_i     (ex_req),
    .ex_addr_i    (ex_addr),
    .ex_data_i    (ex_data),
    .ex_gnt_o     (ex_gnt),
    .lsu_req_i    (lsu_req),
    .lsu_addr_i   (lsu_addr),
    .lsu_data_i   (lsu_data),
    .lsu_gnt_o    (lsu_gnt),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .pend_valid_o (pend_valid),
    .pend_addr_o  (pend_addr),
    .busy_o       (busy),
    .dbg_state_o  (dbg_state)
  );

  ibex_rf_wr_arbiter #(.RV32E(1'b1), .DataWidth(DW)) u_dut_e (
    .clk_int      (clk_int),
    .rst_ni       (rst_ni),
    .ex_req_i     (ex_req_e),
    .ex_addr_i    (ex_addr),
    .ex_data_i    (ex_data),
    .ex_gnt_o     (ex_gnt_e),
    .lsu_req_i    (1'b0),
    .lsu_addr_i   (lsu_addr),
    .lsu_data_i   (lsu_data),
    .lsu_gnt_o    (lsu_gnt_e),
    .rf_we_o      (rf_we_e),
    .rf_waddr_o   (rf_waddr_e),
    .rf_wdata_o   (rf_wdata_e),
    .pend_valid_o (pend_valid_e),
    .pend_addr_o  (pend_addr_e),
    .busy_o       (busy_e),
    .dbg_state_o  (dbg_state_e)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [36:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Every register-file write must match the oldest expected write.
  always @(negedge clk_int) begin
    if (rst_ni === 1'b1 && rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h, want no write", rf_waddr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          failures++;
          $display("FAIL sb_write: got addr=%0d data=%h, want addr=%0d data=%h",
                   rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  // Hard time limit so the run always ends by itself.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic er, input logic [4:0] ea, input logic [DW-1:0] ed,
                       input logic lr, input logic [4:0] la, input logic [DW-1:0] ld);
    ex_req   = er;
    ex_addr  = ea;
    ex_data  = ed;
    lsu_req  = lr;
    lsu_addr = la;
    lsu_data = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk_int);
    #1;
  endtask

  // Release reset and, when the sweep is built in, check the whole sweep.
  task automatic release_and_sweep();
    @(negedge clk_int);
    rst_ni = 1'b1;
    #1;
`ifdef RF_INIT_SWEEP_EN
    // Hold both requests high during the sweep: neither may be granted.
    drive(1'b1, 5'd9, 32'h5, 1'b1, 5'd10, 32'h6);
    for (int k = 1; k <= 31; k++) begin
      exp_q.push_back({5'(k), 32'h0});
    end
    for (int k = 0; k < 31; k++) begin
      checks++;
      if (ex_gnt !== 1'b0 || lsu_gnt !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL sweep_gnt_busy[%0d]: got ex_gnt=%b lsu_gnt=%b busy=%b, want 0 0 1",
                 k, ex_gnt, lsu_gnt, busy);
      end
      @(negedge clk_int);
      #1;
    end
    idle();
    checks++;
    if (busy !== 1'b0 || rf_waddr !== 5'd31) begin
      failures++;
      $display("FAIL sweep_end: got busy=%b waddr=%0d, want busy=0 waddr=31", busy, rf_waddr);
    end
`else
    idle();
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL release_idle: got busy=%b state=%0d, want 0 1", busy, dbg_state);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle();
    ex_req_e = 1'b0;
    #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk_int);
    @(negedge clk_int);
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0 || pend_valid !== 1'b0 ||
        pend_addr !== 5'd0 || busy !== EXP_BUSY_RST || dbg_state !== EXP_STATE_RST) begin
      failures++;
      $display("FAIL reset_values: got we=%b waddr=%0d wdata=%h pv=%b pa=%0d busy=%b st=%0d, want 0 0 0 0 0 %b %0d",
               rf_we, rf_waddr, rf_wdata, pend_valid, pend_addr, busy, dbg_state,
               EXP_BUSY_RST, EXP_STATE_RST);
    end
    release_and_sweep();
  endtask

  task automatic test_ex_only();
    next_cycle();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
    @(negedge clk_int);
    checks++;
    if (ex_gnt !== 1'b1 || lsu_gnt !== 1'b0) begin
      failures++;
      $display("FAIL ex_only_gnt: got ex_gnt=%b lsu_gnt=%b, want 1 0", ex_gnt, lsu_gnt);
    end
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    next_cycle();
    idle();
    @(negedge clk_int);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || pend_valid !== 1'b0) begin
      failures++;
      $display("FAIL ex_only_latency: got we=%b waddr=%0d pv=%b, want 1 5 0", rf_we, rf_waddr, pend_valid);
    end
    next_cycle();
    @(negedge clk_int);
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL idle_hold: got we=%b waddr=%0d wdata=%h, want 0 5 deadbeef", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_collision();
    next_cycle();
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    @(negedge clk_int);
    checks++;
    if (ex_gnt !== 1'b1 || lsu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL collision_gnt: got ex_gnt=%b lsu_gnt=%b, want 1 1", ex_gnt, lsu_gnt);
    end
    exp_q.push_back({5'd7, 32'h22});
    exp_q.push_back({5'd3, 32'h11});
    next_cycle();
    idle();
    @(negedge clk_int);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || pend_valid !== 1'b1 || pend_addr !== 5'd3 ||
        dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL collision_held: got we=%b waddr=%0d pv=%b pa=%0d st=%0d, want 1 7 1 3 2",
               rf_we, rf_waddr, pend_valid, pend_addr, dbg_state);
    end
    next_cycle();
    @(negedge clk_int);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11 || pend_valid !== 1'b0) begin
      failures++;
      $display("FAIL collision_drain: got we=%b waddr=%0d wdata=%h pv=%b, want 1 3 11 0",
               rf_we, rf_waddr, rf_wdata, pend_valid);
    end
  endtask

  task automatic test_held_lsu();
    next_cycle();
    drive(1'b1, 5'd9, 32'hA9, 1'b1, 5'd10, 32'hB0);
    exp_q.push_back({5'd10, 32'hB0});
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b1, 5'd12, 32'hEE, 1'b1, 5'(11 + i), 32'hC0 + 32'(i));
      @(negedge clk_int);
      checks++;
      if (ex_gnt !== 1'b0 || lsu_gnt !== 1'b1 || pend_valid !== 1'b1) begin
        failures++;
        $display("FAIL held_lsu_gnt[%0d]: got ex_gnt=%b lsu_gnt=%b pv=%b, want 0 1 1",
                 i, ex_gnt, lsu_gnt, pend_valid);
      end
      exp_q.push_back({5'(11 + i), 32'hC0 + 32'(i)});
    end
    next_cycle();
    idle();
    exp_q.push_back({5'd9, 32'hA9});
    @(negedge clk_int);
    checks++;
    if (pend_valid !== 1'b1 || pend_addr !== 5'd9) begin
      failures++;
      $display("FAIL held_lsu_retain: got pv=%b pa=%0d, want 1 9", pend_valid, pend_addr);
    end
    next_cycle();
    @(negedge clk_int);
    checks++;
    if (pend_valid !== 1'b0 || rf_waddr !== 5'd9 || rf_wdata !== 32'hA9) begin
      failures++;
      $display("FAIL held_lsu_drain: got pv=%b waddr=%0d wdata=%h, want 0 9 a9", pend_valid, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_held_refill();
    next_cycle();
    drive(1'b1, 5'd20, 32'h14, 1'b1, 5'd21, 32'h15);
    exp_q.push_back({5'd21, 32'h15});
    next_cycle();
    drive(1'b1, 5'd22, 32'h16, 1'b0, 5'd0, '0);
    @(negedge clk_int);
    checks++;
    if (ex_gnt !== 1'b1) begin
      failures++;
      $display("FAIL refill_gnt: got ex_gnt=%b, want 1", ex_gnt);
    end
    exp_q.push_back({5'd20, 32'h14});
    next_cycle();
    idle();
    exp_q.push_back({5'd22, 32'h16});
    @(negedge clk_int);
    checks++;
    if (pend_valid !== 1'b1 || pend_addr !== 5'd22 || rf_waddr !== 5'd20) begin
      failures++;
      $display("FAIL refill_held: got pv=%b pa=%0d waddr=%0d, want 1 22 20", pend_valid, pend_addr, rf_waddr);
    end
    next_cycle();
    @(negedge clk_int);
    checks++;
    if (pend_valid !== 1'b0 || rf_waddr !== 5'd22) begin
      failures++;
      $display("FAIL refill_drain: got pv=%b waddr=%0d, want 0 22", pend_valid, rf_waddr);
    end
  endtask

  task automatic test_x0();
    next_cycle();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, '0);
    @(negedge clk_int);
    checks++;
    if (ex_gnt !== 1'b1) begin
      failures++;
      $display("FAIL x0_gnt: got ex_gnt=%b, want 1", ex_gnt);
    end
    next_cycle();
    idle();
    @(negedge clk_int);
    checks++;
    if (rf_we !== 1'b0 || dbg_state !== 2'd1 || pend_valid !== 1'b0) begin
      failures++;
      $display("FAIL x0_no_write: got we=%b st=%0d pv=%b, want 0 1 0", rf_we, dbg_state, pend_valid);
    end
    // An LSU write to x0 while the buffer is full drains the buffer.
    next_cycle();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    exp_q.push_back({5'd6, 32'h66});
    next_cycle();
    drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h99);
    @(negedge clk_int);
    checks++;
    if (lsu_gnt !== 1'b1 || pend_valid !== 1'b1) begin
      failures++;
      $display("FAIL lsu_x0_gnt: got lsu_gnt=%b pv=%b, want 1 1", lsu_gnt, pend_valid);
    end
    exp_q.push_back({5'd4, 32'h44});
    next_cycle();
    idle();
    @(negedge clk_int);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || pend_valid !== 1'b0) begin
      failures++;
      $display("FAIL lsu_x0_drain: got we=%b waddr=%0d pv=%b, want 1 4 0", rf_we, rf_waddr, pend_valid);
    end
  endtask

  task automatic test_rv32e();
    next_cycle();
    drive(1'b1, 5'h13, 32'h1234, 1'b0, 5'd0, '0);
    ex_req_e = 1'b1;
    exp_q.push_back({5'h13, 32'h1234});
    next_cycle();
    idle();
    ex_req_e = 1'b0;
    @(negedge clk_int);
    checks++;
    if (rf_we_e !== 1'b1 || rf_waddr_e !== 5'h03 || rf_wdata_e !== 32'h1234) begin
      failures++;
      $display("FAIL rv32e_trunc: got we=%b waddr=%h wdata=%h, want 1 03 1234", rf_we_e, rf_waddr_e, rf_wdata_e);
    end
    checks++;
    if (rf_waddr !== 5'h13) begin
      failures++;
      $display("FAIL rv32i_full_addr: got waddr=%h, want 13", rf_waddr);
    end
  endtask

  task automatic test_reset_held();
    next_cycle();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 32'h88);
    exp_q.push_back({5'd8, 32'h88});
    next_cycle();
    idle();
    @(negedge clk_int);
    checks++;
    if (pend_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_held_setup: got pv=%b, want 1", pend_valid);
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if (pend_valid !== 1'b0 || rf_we !== 1'b0 || pend_addr !== 5'd0 || dbg_state !== EXP_STATE_RST) begin
      failures++;
      $display("FAIL reset_async: got pv=%b we=%b pa=%0d st=%0d, want 0 0 0 %0d",
               pend_valid, rf_we, pend_addr, dbg_state, EXP_STATE_RST);
    end
    release_and_sweep();
    // The discarded buffer entry must never be written after reset.
    repeat (3) next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_ex_only();
    test_collision();
    test_held_lsu();
    test_held_refill();
    test_x0();
    test_rv32e();
    test_reset_held();
    repeat (2) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drained: got %0d pending writes, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
